// File: rtl/uart_tx_fsm_pkg.sv
// uart_tx_fsm_pkg
//   Shared definitions for the UART TX control path and its output multiplexer:
//   the multiplexer select codes, the FSM state type (whose encoding equals the
//   select code, so the state register drives mux_sel directly) and a helper
//   for sizing counters.
package uart_tx_fsm_pkg;

  localparam logic [2:0] SEL_IDLE  = 3'd0;
  localparam logic [2:0] SEL_START = 3'd1;
  localparam logic [2:0] SEL_DATA  = 3'd2;
  localparam logic [2:0] SEL_PAR   = 3'd3;
  localparam logic [2:0] SEL_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = SEL_IDLE,
    ST_START  = SEL_START,
    ST_DATA   = SEL_DATA,
    ST_PARITY = SEL_PAR,
    ST_STOP   = SEL_STOP
  } state_t;

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc
//   Combinational parity generator, shared between the TX path and a future
//   RX checker.
//   i_data    : word to protect
//   i_par_typ : 0 = even, 1 = odd
//   o_par_bit : parity bit that makes the word plus parity even/odd
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par_bit
);

  assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
//   Frame sequencer feeding the UART TX output multiplexer. Accepts a byte on
//   a one-cycle DATA_VALID strobe, paces each frame bit for CLKS_PER_BIT
//   clocks and drives the multiplexer select, serial data and parity inputs.
//   CLK        : clock, rising edge
//   RST        : asynchronous active-low reset
//   P_DATA     : payload, sampled on acceptance
//   DATA_VALID : request strobe (accepted in IDLE or the last STOP cycle)
//   PAR_EN     : parity bit inserted when 1, sampled on acceptance
//   PAR_TYP    : 0 even, 1 odd, sampled on acceptance
//   busy       : frame in progress
//   mux_sel    : 0 idle, 1 start, 2 data, 3 parity, 4 stop
//   ser_data   : current data bit, LSB first
//   par_bit    : parity of the latched word
module uart_tx_fsm
  import uart_tx_fsm_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  busy,
  output logic [2:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BIT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_bit_end;
  logic                  w_accept;
  logic                  w_par_calc;

  assign w_bit_end = (r_clk_cnt == CNT_LAST);

  // Parity is evaluated on the incoming word and captured with it; this equals
  // the parity of the latched word while the shift register is free to shift.
  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (P_DATA),
    .i_par_typ (PAR_TYP),
    .o_par_bit (w_par_calc)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (DATA_VALID) begin
          w_accept = 1'b1;
          w_next   = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == BIT_LAST))
          w_next = r_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (DATA_VALID) begin
            w_accept = 1'b1;
            w_next   = ST_START;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if ((w_next != r_state) || (r_state == ST_IDLE) || w_bit_end)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + 1'b1;

      if (w_next != ST_DATA)
        r_bit_cnt <= '0;
      else if ((r_state == ST_DATA) && w_bit_end)
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shreg   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_shreg   <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_bit <= w_par_calc;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      r_shreg   <= r_shreg >> 1;
    end
  end

  assign mux_sel  = r_state;
  assign busy     = (r_state != ST_IDLE);
  assign ser_data = r_shreg[0];
  assign par_bit  = r_par_bit;

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  bit         use4;

  always #5 CLK = ~CLK;

  logic       dv1, dv4;
  logic       busy1, ser1, par1, busy4, ser4, par4;
  logic [2:0] sel1, sel4;

  assign dv1 = DATA_VALID & ~use4;
  assign dv4 = DATA_VALID &  use4;

  uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(dv1),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .busy(busy1), .mux_sel(sel1), .ser_data(ser1), .par_bit(par1)
  );

  uart_tx_fsm #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(dv4),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .busy(busy4), .mux_sel(sel4), .ser_data(ser4), .par_bit(par4)
  );

  logic [2:0] v_sel;
  logic       v_busy, v_ser, v_par;
  assign v_sel  = use4 ? sel4  : sel1;
  assign v_busy = use4 ? busy4 : busy1;
  assign v_ser  = use4 ? ser4  : ser1;
  assign v_par  = use4 ? par4  : par1;

  int n_pass  = 0;
  int n_total = 0;

  int         hook_idx = -1;
  logic [7:0] hook_d;
  logic       hook_en, hook_typ;

  typedef struct {
    logic [7:0] d;
    logic       en;
    logic       typ;
    logic       use4;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the frame is START, 8 data bits LSB first, optional parity,
  // STOP, each held cpb cycles. Called at #1 after the accepting edge.
  task automatic expect_frame(input logic [7:0] d, input logic en, input logic typ,
                              output int blen);
    logic [2:0] qs[$];
    logic       qd[$];
    int         cpb;
    logic       ep;
    cpb = use4 ? 4 : 1;
    ep  = ((($countones(d)) % 2) == 1) ^ typ;
    repeat (cpb) begin qs.push_back(3'd1); qd.push_back(1'b0); end
    for (int b = 0; b < 8; b++)
      repeat (cpb) begin qs.push_back(3'd2); qd.push_back(d[b]); end
    if (en) repeat (cpb) begin qs.push_back(3'd3); qd.push_back(1'b0); end
    repeat (cpb) begin qs.push_back(3'd4); qd.push_back(1'b0); end
    blen = 0;
    for (int i = 0; i < qs.size(); i++) begin
      if (i > 0) begin
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
      end
      chk("mux_sel", v_sel, qs[i]);
      chk("busy", v_busy, 1);
      if (qs[i] == 3'd2) chk("ser_data", v_ser, qd[i]);
      chk("par_bit", v_par, ep);
      if (v_busy) blen++;
      if (i == hook_idx) begin
        DATA_VALID = 1'b1;
        P_DATA     = hook_d;
        PAR_EN     = hook_en;
        PAR_TYP    = hook_typ;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic typ, output int blen);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    P_DATA  = 8'($urandom);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    expect_frame(d, en, typ, blen);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      chk("idle_sel", v_sel, 0);
      chk("idle_busy", v_busy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int blen;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 11};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 11};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 11};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 40};
    vecs[4] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 10};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 44};

    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    use4 = 1'b0;
    #12;
    chk("rst_sel1", sel1, 0);  chk("rst_busy1", busy1, 0);
    chk("rst_ser1", ser1, 0);  chk("rst_par1", par1, 0);
    chk("rst_sel4", sel4, 0);  chk("rst_busy4", busy4, 0);
    chk("rst_ser4", ser4, 0);  chk("rst_par4", par4, 0);
    @(negedge CLK); RST = 1'b1;
    idle_check(2);

    // Directed table
    foreach (vecs[k]) begin
      use4 = vecs[k].use4;
      send(vecs[k].d, vecs[k].en, vecs[k].typ, blen);
      chk("frame_len", blen, vecs[k].exp_len);
      chk("par_table", v_par, vecs[k].exp_par);
      idle_check(2);
    end

    // Strobe during DATA is dropped, not queued
    use4 = 1'b0;
    hook_idx = 3; hook_d = 8'h55; hook_en = 1'b1; hook_typ = 1'b1;
    send(8'h12, 1'b0, 1'b0, blen);
    hook_idx = -1;
    chk("ignore_len", blen, 10);
    idle_check(3);

    // Back-to-back from the last STOP cycle, CLKS_PER_BIT=1
    hook_idx = 9; hook_d = 8'h3C; hook_en = 1'b1; hook_typ = 1'b0;
    send(8'h81, 1'b0, 1'b1, blen);
    hook_idx = -1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    expect_frame(8'h3C, 1'b1, 1'b0, blen);
    chk("b2b_len", blen, 11);
    idle_check(2);

    // Back-to-back with CLKS_PER_BIT=4
    use4 = 1'b1;
    hook_idx = 39; hook_d = 8'hC6; hook_en = 1'b0; hook_typ = 1'b1;
    send(8'h5A, 1'b0, 1'b0, blen);
    hook_idx = -1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    expect_frame(8'hC6, 1'b0, 1'b1, blen);
    chk("b2b4_len", blen, 40);
    idle_check(2);

    // Strobe one cycle before the end of STOP is dropped
    hook_idx = 38; hook_d = 8'h99; hook_en = 1'b1; hook_typ = 1'b1;
    send(8'h24, 1'b0, 1'b0, blen);
    hook_idx = -1;
    idle_check(3);

    // Asynchronous reset during DATA bit 3
    use4 = 1'b0;
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("pre_rst_sel", v_sel, 2);
    #2 RST = 1'b0;
    #1;
    chk("arst_sel", v_sel, 0);
    chk("arst_busy", v_busy, 0);
    chk("arst_ser", v_ser, 0);
    chk("arst_par", v_par, 0);
    @(negedge CLK); RST = 1'b1;
    idle_check(4);
    send(8'h6E, 1'b1, 1'b0, blen);
    chk("post_rst_len", blen, 11);
    idle_check(1);

    // Randomized frames against the reference
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       en, typ;
      int         cpb;
      use4 = (k % 5 == 4);
      cpb  = use4 ? 4 : 1;
      d    = 8'($urandom);
      en   = 1'($urandom);
      typ  = 1'($urandom);
      idle_check($urandom_range(0, 3));
      send(d, en, typ, blen);
      chk("rand_len", blen, (10 + int'(en)) * cpb);
      idle_check(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
